// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage: data widths, the
// registered output payload and the load-use match helper.
package operand_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO  = 5'd0;
    localparam xlen_t     XLEN_ZERO = 32'h0000_0000;

    typedef struct packed {
        xlen_t     pc;
        xlen_t     imm;
        xlen_t     op1;
        xlen_t     op2;
        reg_addr_t rd;
        logic      reg_we;
    } fetch_payload_t;

    localparam fetch_payload_t PAYLOAD_ZERO = '{
        pc:     32'h0000_0000,
        imm:    32'h0000_0000,
        op1:    32'h0000_0000,
        op2:    32'h0000_0000,
        rd:     5'd0,
        reg_we: 1'b0
    };

    // A source only creates a load-use dependency when it is actually read.
    function automatic logic load_use_hit(input logic use_src, input reg_addr_t rs,
                                          input reg_addr_t ex_rd);
        return use_src && (rs == ex_rd);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-to-fetch and fetch-to-execute handshakes with their payload fields.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic      in_valid;
    logic      in_ready;
    xlen_t     in_pc;
    xlen_t     in_imm;
    reg_addr_t in_rs1;
    reg_addr_t in_rs2;
    reg_addr_t in_rd;
    logic      in_use_rs1;
    logic      in_use_rs2;
    logic      in_reg_we;

    logic      out_valid;
    logic      out_ready;
    xlen_t     out_pc;
    xlen_t     out_imm;
    xlen_t     out_op1;
    xlen_t     out_op2;
    reg_addr_t out_rd;
    logic      out_reg_we;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_reg_we, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_op1, out_op2,
               out_rd, out_reg_we
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_reg_we, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_op1, out_op2,
               out_rd, out_reg_we
    );

endinterface

// File: rtl/operand_fetch_forward.sv
// Per-source operand select: x0, then execute-stage bypass, then writeback
// bypass, then the register file read value.
module operand_forward
    import operand_fetch_pkg::*;
(
    input  reg_addr_t rs_i,
    input  xlen_t     rf_data_i,
    input  logic      ex_we_i,
    input  logic      ex_load_i,
    input  reg_addr_t ex_rd_i,
    input  xlen_t     ex_data_i,
    input  logic      wb_we_i,
    input  reg_addr_t wb_rd_i,
    input  xlen_t     wb_data_i,
    output xlen_t     op_o
);

    // A load still in execute has no data yet, so it is never a bypass source.
    always_comb begin
        op_o = rf_data_i;
        if (rs_i == REG_ZERO) begin
            op_o = XLEN_ZERO;
        end else if (ex_we_i && !ex_load_i && (ex_rd_i == rs_i)) begin
            op_o = ex_data_i;
        end else if (wb_we_i && (wb_rd_i == rs_i)) begin
            op_o = wb_data_i;
        end else begin
            op_o = rf_data_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads/bypasses source operands, stalls on load-use
// hazards and holds one instruction in a registered output slot.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_fetch_if.slave         bus,
    output reg_addr_t              rf_rs1,
    output reg_addr_t              rf_rs2,
    input  xlen_t                  rf_data1,
    input  xlen_t                  rf_data2,
    input  logic                   ex_we,
    input  reg_addr_t              ex_rd,
    input  xlen_t                  ex_data,
    input  logic                   ex_load,
    input  logic                   wb_we,
    input  reg_addr_t              wb_rd,
    input  xlen_t                  wb_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_ZERO = {STALL_CNT_W{1'b0}};

    fetch_payload_t          payload_q, payload_d, payload_new_s;
    logic                    out_valid_q, out_valid_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;
    logic                    hazard_s, in_ready_s, accept_s;
    xlen_t                   op1_s, op2_s;

    assign rf_rs1 = bus.in_rs1;
    assign rf_rs2 = bus.in_rs2;

    operand_forward u_fwd_rs1 (
        .rs_i(bus.in_rs1), .rf_data_i(rf_data1),
        .ex_we_i(ex_we), .ex_load_i(ex_load), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .op_o(op1_s)
    );

    operand_forward u_fwd_rs2 (
        .rs_i(bus.in_rs2), .rf_data_i(rf_data2),
        .ex_we_i(ex_we), .ex_load_i(ex_load), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .op_o(op2_s)
    );

    assign hazard_s   = bus.in_valid && ex_we && ex_load && (ex_rd != REG_ZERO) &&
                        (load_use_hit(bus.in_use_rs1, bus.in_rs1, ex_rd) ||
                         load_use_hit(bus.in_use_rs2, bus.in_rs2, ex_rd));
    assign in_ready_s = (!out_valid_q || bus.out_ready) && !hazard_s && !flush;
    assign accept_s   = bus.in_valid && in_ready_s;

    assign payload_new_s = '{
        pc:     bus.in_pc,
        imm:    bus.in_imm,
        op1:    op1_s,
        op2:    op2_s,
        rd:     bus.in_rd,
        reg_we: bus.in_reg_we
    };

    // Output slot and stall counter next state; flush beats accept beats drain.
    always_comb begin
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        stall_d     = stall_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            payload_d   = payload_new_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (hazard_s && !flush && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            payload_q   <= PAYLOAD_ZERO;
            stall_q     <= STALL_ZERO;
        end else begin
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = payload_q.pc;
    assign bus.out_imm    = payload_q.imm;
    assign bus.out_op1    = payload_q.op1;
    assign bus.out_op2    = payload_q.op2;
    assign bus.out_rd     = payload_q.rd;
    assign bus.out_reg_we = payload_q.reg_we;
    assign stall_count    = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// run against a rule-level reference model; a 2-bit counter copy checks saturation.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if bus ();
    operand_fetch_if bus2 ();

    reg_addr_t rf_rs1, rf_rs2, rf_rs1_b, rf_rs2_b;
    xlen_t     rf_data1, rf_data2, ex_data, wb_data;
    logic      ex_we, ex_load, wb_we, flush;
    reg_addr_t ex_rd, wb_rd;
    logic [15:0] stall16;
    logic [1:0]  stall2;

    int checks = 0;
    int failures = 0;

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.in_pc      = bus.in_pc;
    assign bus2.in_imm     = bus.in_imm;
    assign bus2.in_rs1     = bus.in_rs1;
    assign bus2.in_rs2     = bus.in_rs2;
    assign bus2.in_rd      = bus.in_rd;
    assign bus2.in_use_rs1 = bus.in_use_rs1;
    assign bus2.in_use_rs2 = bus.in_use_rs2;
    assign bus2.in_reg_we  = bus.in_reg_we;
    assign bus2.out_ready  = bus.out_ready;

    operand_fetch #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_load(ex_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall_count(stall16)
    );

    operand_fetch #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .rf_rs1(rf_rs1_b), .rf_rs2(rf_rs2_b), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_load(ex_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall_count(stall2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0;   bus.in_pc = 32'h0;    bus.in_imm = 32'h0;
        bus.in_rs1 = 5'd0;     bus.in_rs2 = 5'd0;    bus.in_rd = 5'd0;
        bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_reg_we = 1'b0;
        bus.out_ready = 1'b1;
        rf_data1 = 32'h0; rf_data2 = 32'h0;
        ex_we = 1'b0; ex_rd = 5'd0; ex_data = 32'h0; ex_load = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        bus.in_valid = 1'b1; bus.in_pc = 32'hCAFE_0000; bus.in_rs1 = 5'd2;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || stall16 !== 16'd0 || stall2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl: valid=%0b stall=%0d/%0d required 0/0/0", bus.out_valid, stall16, stall2);
        end
        checks++;
        if ({bus.out_pc, bus.out_imm, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_reg_we} !== 134'd0) begin
            failures++;
            $display("FAIL reset_payload: pc=%h imm=%h op1=%h op2=%h rd=%0d we=%0b required all 0",
                     bus.out_pc, bus.out_imm, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_reg_we);
        end
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_wb_forward();
        do_reset();
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd5; bus.in_use_rs1 = 1'b1; bus.in_pc = 32'h0000_0100;
        bus.in_rd = 5'd9; bus.in_reg_we = 1'b1;
        rf_data1 = 32'h0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || rf_rs1 !== 5'd5) begin
            failures++;
            $display("FAIL wb_ready: in_ready=%0b rf_rs1=%0d required 1/5", bus.in_ready, rf_rs1);
        end
        tick();
        set_idle();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'hDEAD_BEEF || bus.out_pc !== 32'h0000_0100 ||
            bus.out_rd !== 5'd9 || bus.out_reg_we !== 1'b1) begin
            failures++;
            $display("FAIL wb_forward: valid=%0b op1=%h pc=%h rd=%0d we=%0b required 1/deadbeef/00000100/9/1",
                     bus.out_valid, bus.out_op1, bus.out_pc, bus.out_rd, bus.out_reg_we);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.in_valid = 1'b1; bus.in_rs2 = 5'd3; bus.in_use_rs2 = 1'b1; bus.in_rs1 = 5'd7;
        rf_data2 = 32'h0000_AAAA;
        ex_we = 1'b1; ex_load = 1'b1; ex_rd = 5'd3; ex_data = 32'h5555_5555;
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_use_ready[%0d]: in_ready=%0b required 0", c, bus.in_ready);
            end
            tick();
        end
        checks++;
        if (stall16 !== 16'd2 || stall2 !== 2'd2 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_use_stall: stall=%0d/%0d valid=%0b required 2/2/0", stall16, stall2, bus.out_valid);
        end
        ex_load = 1'b0; ex_data = 32'h0000_1234;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_use_release: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        set_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_op2 !== 32'h0000_1234 || stall16 !== 16'd2) begin
            failures++;
            $display("FAIL load_use_data: valid=%0b op2=%h stall=%0d required 1/00001234/2",
                     bus.out_valid, bus.out_op2, stall16);
        end
    endtask

    task automatic test_x0();
        do_reset();
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd0; bus.in_use_rs1 = 1'b1; bus.in_rs2 = 5'd0;
        rf_data1 = 32'h5555_5555; rf_data2 = 32'h6666_6666;
        ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFF_FFFF; ex_load = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_no_hazard: in_ready=%0b required 1", bus.in_ready);
        end
        ex_load = 1'b0; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h7777_7777;
        tick();
        set_idle();
        checks++;
        if (bus.out_op1 !== 32'h0 || bus.out_op2 !== 32'h0) begin
            failures++;
            $display("FAIL x0_operand: op1=%h op2=%h required 0/0", bus.out_op1, bus.out_op2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.in_valid = 1'b1; bus.in_pc = 32'h0000_0200; bus.in_rs1 = 5'd1; rf_data1 = 32'h0000_0011;
        tick();
        bus.out_ready = 1'b0;
        bus.in_pc = 32'h0000_0300; bus.in_rs1 = 5'd2;
        for (int c = 0; c < 3; c++) begin
            rf_data1 = $urandom();
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d]: in_ready=%0b required 0", c, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0200 || bus.out_op1 !== 32'h0000_0011) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%0b pc=%h op1=%h required 1/00000200/00000011",
                         c, bus.out_valid, bus.out_pc, bus.out_op1);
            end
        end
        bus.out_ready = 1'b1; rf_data1 = 32'h0000_0022;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        set_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0300 || bus.out_op1 !== 32'h0000_0022) begin
            failures++;
            $display("FAIL back_to_back: valid=%0b pc=%h op1=%h required 1/00000300/00000022",
                     bus.out_valid, bus.out_pc, bus.out_op1);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: valid=%0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.in_valid = 1'b1; bus.in_pc = 32'h0000_0400;
        tick();
        bus.in_pc = 32'h0000_0500; flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%0b required 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill: valid=%0b required 0", bus.out_valid);
        end
        bus.in_use_rs1 = 1'b1; bus.in_rs1 = 5'd4; ex_we = 1'b1; ex_load = 1'b1; ex_rd = 5'd4;
        tick();
        tick();
        checks++;
        if (stall16 !== 16'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: stall=%0d valid=%0b required 0/0", stall16, bus.out_valid);
        end
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.in_valid = 1'b1; bus.in_pc = 32'h0000_0600;
        tick();
        bus.out_ready = 1'b0;
        bus.in_rs1 = 5'd6; bus.in_use_rs1 = 1'b1;
        ex_we = 1'b1; ex_load = 1'b1; ex_rd = 5'd6;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (stall16 !== 16'(k) || stall2 !== 2'((k > 3) ? 3 : k)) begin
                failures++;
                $display("FAIL saturate[%0d]: stall=%0d/%0d required %0d/%0d", k, stall16, stall2, k, (k > 3) ? 3 : k);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stall16 !== 16'd0 || stall2 !== 2'd0 || bus.out_valid !== 1'b0 || bus2.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall: stall=%0d/%0d valid=%0b/%0b required 0/0/0/0",
                     stall16, stall2, bus.out_valid, bus2.out_valid);
        end
        set_idle();
    endtask

    function automatic xlen_t ref_operand(input reg_addr_t idx, input xlen_t rf);
        if (idx == 5'd0) return 32'h0;
        if (ex_we && !ex_load && ex_rd == idx) return ex_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    task automatic test_random();
        logic m_valid;
        xlen_t m_pc, m_imm, m_op1, m_op2;
        reg_addr_t m_rd;
        logic m_we, exp_hazard, exp_ready;
        int m_stall;
        do_reset();
        m_valid = 1'b0; m_pc = 32'h0; m_imm = 32'h0; m_op1 = 32'h0; m_op2 = 32'h0;
        m_rd = 5'd0; m_we = 1'b0; m_stall = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(49, 0) == 0);
            bus.in_valid = ($urandom_range(3, 0) != 0);
            bus.in_pc = $urandom(); bus.in_imm = $urandom();
            bus.in_rs1 = 5'($urandom_range(3, 0)); bus.in_rs2 = 5'($urandom_range(3, 0));
            bus.in_rd = 5'($urandom_range(31, 0)); bus.in_reg_we = 1'($urandom_range(1, 0));
            bus.in_use_rs1 = 1'($urandom_range(1, 0)); bus.in_use_rs2 = 1'($urandom_range(1, 0));
            bus.out_ready = ($urandom_range(9, 0) < 7);
            rf_data1 = $urandom(); rf_data2 = $urandom();
            ex_we = 1'($urandom_range(1, 0)); ex_rd = 5'($urandom_range(3, 0));
            ex_data = $urandom(); ex_load = ($urandom_range(9, 0) < 3);
            wb_we = 1'($urandom_range(1, 0)); wb_rd = 5'($urandom_range(3, 0)); wb_data = $urandom();
            flush = ($urandom_range(9, 0) == 0);
            #1;
            exp_hazard = bus.in_valid && ex_we && ex_load && ex_rd != 5'd0 &&
                         ((bus.in_use_rs1 && ex_rd == bus.in_rs1) || (bus.in_use_rs2 && ex_rd == bus.in_rs2));
            exp_ready = (!m_valid || bus.out_ready) && !exp_hazard && !flush;
            checks++;
            if (bus.in_ready !== exp_ready || rf_rs1 !== bus.in_rs1 || rf_rs2 !== bus.in_rs2) begin
                failures++;
                $display("FAIL rand_ready[%0d]: in_ready=%0b rf=%0d/%0d required %0b/%0d/%0d",
                         n, bus.in_ready, rf_rs1, rf_rs2, exp_ready, bus.in_rs1, bus.in_rs2);
            end
            if (rst) begin
                m_valid = 1'b0; m_stall = 0;
            end else begin
                if (exp_hazard && !flush) m_stall = m_stall + 1;
                if (flush) m_valid = 1'b0;
                else if (bus.in_valid && exp_ready) begin
                    m_valid = 1'b1; m_pc = bus.in_pc; m_imm = bus.in_imm;
                    m_op1 = ref_operand(bus.in_rs1, rf_data1); m_op2 = ref_operand(bus.in_rs2, rf_data2);
                    m_rd = bus.in_rd; m_we = bus.in_reg_we;
                end else if (bus.out_ready) m_valid = 1'b0;
            end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || stall16 !== 16'((m_stall > 65535) ? 65535 : m_stall) ||
                stall2 !== 2'((m_stall > 3) ? 3 : m_stall)) begin
                failures++;
                $display("FAIL rand_state[%0d]: valid=%0b stall=%0d/%0d required %0b/%0d/%0d",
                         n, bus.out_valid, stall16, stall2, m_valid, m_stall, (m_stall > 3) ? 3 : m_stall);
            end
            if (m_valid) begin
                checks++;
                if (bus.out_pc !== m_pc || bus.out_imm !== m_imm || bus.out_op1 !== m_op1 ||
                    bus.out_op2 !== m_op2 || bus.out_rd !== m_rd || bus.out_reg_we !== m_we) begin
                    failures++;
                    $display("FAIL rand_payload[%0d]: pc=%h imm=%h op1=%h op2=%h rd=%0d we=%0b required %h/%h/%h/%h/%0d/%0b",
                             n, bus.out_pc, bus.out_imm, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_reg_we,
                             m_pc, m_imm, m_op1, m_op2, m_rd, m_we);
                end
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_wb_forward();
        test_load_use();
        test_x0();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid, in_ready  in/out  1/1  decode-to-fetch handshake.
REQ-005 in_pc, in_imm  in  32/32  instruction PC and decoded immediate.
REQ-006 in_rs1, in_rs2, in_rd  in  5/5/5  source and destination register indices.
REQ-007 in_use_rs1, in_use_rs2, in_reg_we  in  1/1/1  source-used flags; destination write enable.
REQ-008 rf_rs1, rf_rs2  out  5/5  register file read addresses; combinational copies of in_rs1/in_rs2.
REQ-009 rf_data1, rf_data2  in  32/32  register file read data; combinational, pre-write value.
REQ-010 ex_we, ex_rd, ex_data, ex_load  in  1/5/32/1  execute-stage result; ex_load=1 means data not yet valid.
REQ-011 wb_we, wb_rd, wb_data  in  1/5/32  writeback port, identical to the register file write port.
REQ-012 flush  in  1  kill the instruction in flight.
REQ-013 out_valid, out_ready  out/in  1/1  fetch-to-execute handshake.
REQ-014 out_pc, out_imm, out_op1, out_op2  out  32 each  registered operands.
REQ-015 out_rd, out_reg_we  out  5/1  registered destination.
REQ-016 stall_count  out  STALL_CNT_W  number of load-use stall cycles.

Function
REQ-017 Operand selection SHALL use this priority for each source: index 0 gives 0; else ex_we && !ex_load && ex_rd match gives ex_data; else wb_we && wb_rd match gives wb_data; else rf_dataN.
REQ-018 Hazard SHALL be asserted when in_valid && ex_we && ex_load && ex_rd!=0 && ((in_use_rs1 && ex_rd==in_rs1) || (in_use_rs2 && ex_rd==in_rs2)).
REQ-019 in_ready SHALL be (!out_valid || out_ready) && !hazard && !flush.
REQ-020 When in_valid && in_ready, the output register SHALL load the selected operands, pc, imm, rd, and reg_we, and set out_valid=1 on the next edge; latency is 1 cycle.
REQ-021 When out_valid && out_ready and no new accept occurs, out_valid SHALL clear on the next edge.
REQ-022 When out_valid && !out_ready, all out_* SHALL hold stable.
REQ-023 flush SHALL clear out_valid on the next edge, take priority over accept and hold, and leave stall_count unchanged.
REQ-024 stall_count SHALL increment by 1 on each cycle where hazard=1 and flush=0, saturating at all-ones.
REQ-025 An unused source (in_use_rsN=0) SHALL never cause a hazard; its operand value is still produced per REQ-017.
REQ-026 A simultaneous ex and wb match SHALL select ex_data; ex_load=1 SHALL never be forwarded.
REQ-027 Datapath out_* fields SHALL be don't-care when out_valid=0; they update only on accept.

Reset
REQ-028 When rst=1 at a rising edge: out_valid=0, stall_count=0, and out_pc, out_imm, out_op1, out_op2, out_rd, out_reg_we all 0.
REQ-029 rst SHALL override flush, accept, and hold; no partial instruction survives reset.

Structure
REQ-030 A shared package SHALL define XLEN=32, REG_ADDR_W=5, and a struct for the output payload (pc, imm, op1, op2, rd, reg_we).
REQ-031 One sub-module, operand_forward, SHALL implement the combinational per-source select of REQ-017 and be instantiated twice.
REQ-032 The block SHALL contain no register file storage; it instantiates no copy of the register array.

Verification
REQ-033 wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, rf_data1=0, in_rs1=5 accepted -> next cycle out_op1=0xDEADBEEF, out_valid=1.
REQ-034 ex_we=1, ex_load=1, ex_rd=3, in_rs2=3, in_use_rs2=1 for 2 cycles, then ex_load=0, ex_data=0x1234 -> in_ready=0 for 2 cycles, stall_count=2, then accept with out_op2=0x1234.
REQ-035 in_rs1=0, ex_rd=0, ex_we=1, ex_data=0xFFFFFFFF -> out_op1=0.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable and in_ready=0; out_ready=1 -> next instruction accepted in the same cycle.
REQ-037 flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, no instruction accepted.
REQ-038 STALL_CNT_W=2 with a 5-cycle hazard -> stall_count saturates at 3; rst=1 mid-stall -> stall_count=0, out_valid=0.
